// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package mem_access_pkg;

   localparam int unsigned LANE_W     = 8;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [1:0] {
      SIZE_B   = 2'b00,
      SIZE_H   = 2'b01,
      SIZE_W   = 2'b10,
      SIZE_BAD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStore,
      StRmwRd,
      StRmwWr,
      StResp
   } state_e;

endpackage

// File: rtl/load_align.sv
// Extracts a byte/halfword lane from a memory word and sign- or zero-extends it.
module load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  size_e       size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [15:0] shifted;

   always_comb begin
      shifted = word[15:0];
      unique case (offset)
         2'd0: shifted = word[15:0];
         2'd1: shifted = word[23:8];
         2'd2: shifted = word[31:16];
         2'd3: shifted = {8'h00, word[31:24]};
         default: shifted = word[15:0];
      endcase
   end

   always_comb begin
      data = word;
      case (size)
         SIZE_B: data = is_unsigned ? {{(32-LANE_W){1'b0}}, shifted[LANE_W-1:0]}
                                    : {{(32-LANE_W){shifted[LANE_W-1]}}, shifted[LANE_W-1:0]};
         SIZE_H: data = is_unsigned ? {16'h0000, shifted}
                                    : {{16{shifted[15]}}, shifted};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: byte-addressed requests to a word-addressed memory,
// with read-modify-write for sub-word stores.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam int unsigned OFFSET_W = $clog2(WORD_BYTES);

   state_e      state_q, state_d;
   logic        write_q, unsigned_q, err_q;
   size_e       size_q;
   logic [31:0] addr_q, wdata_q, data_q;
   logic        req_err;
   logic [31:0] aligned, merged;
   logic [OFFSET_W-1:0] offset_q;

   assign offset_q    = addr_q[OFFSET_W-1:0];
   assign mem_address = {2'b00, addr_q[31:2]};

   always_comb begin
      req_err = 1'b0;
      case (size_e'(req_size))
         SIZE_H:   req_err = req_addr[0];
         SIZE_W:   req_err = |req_addr[1:0];
         SIZE_BAD: req_err = 1'b1;
         default:  req_err = 1'b0;
      endcase
      if ({2'b00, req_addr[31:2]} >= DEPTH_WORDS) req_err = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (req_err)                           state_d = StResp;
               else if (!req_write)                   state_d = StLoad;
               else if (size_e'(req_size) == SIZE_W)  state_d = StStore;
               else                                   state_d = StRmwRd;
            end
         end
         StLoad:  state_d = StResp;
         StStore: state_d = StResp;
         StRmwRd: state_d = StRmwWr;
         StRmwWr: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Only the addressed lane(s) of the previously read word are replaced.
   always_comb begin
      merged = data_q;
      case (size_q)
         SIZE_B:  merged[{offset_q, 3'b000} +: 8]   = wdata_q[7:0];
         SIZE_H:  merged[{offset_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   load_align u_load_align (
      .word        (data_q),
      .offset      (offset_q),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .data        (aligned)
   );

   always_comb begin
      req_ready        = (state_q == StIdle);
      resp_valid       = (state_q == StResp);
      resp_error       = resp_valid && err_q;
      resp_rdata       = (resp_valid && !write_q && !err_q) ? aligned : 32'h0;
      mem_write_enable = (state_q == StStore) || (state_q == StRmwWr);
      mem_write_data   = 32'h0;
      if (state_q == StStore)      mem_write_data = wdata_q;
      else if (state_q == StRmwWr) mem_write_data = merged;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         write_q    <= 1'b0;
         unsigned_q <= 1'b0;
         err_q      <= 1'b0;
         size_q     <= SIZE_B;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         data_q     <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && req_valid) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            err_q      <= req_err;
            size_q     <= size_e'(req_size);
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
         end
         if (state_q == StLoad || state_q == StRmwRd) data_q <= mem_read_data;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready, resp_valid, resp_error, mem_write_enable;
   logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

   always #5 clock = ~clock;

   mem_access_unit #(.DEPTH_WORDS(256)) dut (
      .clock            (clock),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_size         (req_size),
      .req_unsigned     (req_unsigned),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .resp_error       (resp_error),
      .mem_address      (mem_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   logic [31:0] tb_mem [256];
   assign mem_read_data = (mem_address < 32'd256) ? tb_mem[mem_address[7:0]] : 32'h0;
   always @(posedge clock)
      if (mem_write_enable && mem_address < 32'd256) tb_mem[mem_address[7:0]] <= mem_write_data;

   typedef struct {int due; logic [31:0] rdata; logic err;} resp_t;
   typedef struct {int due; logic [31:0] addr; logic [31:0] data;} wr_t;
   resp_t rq[$];
   wr_t   wq[$];
   logic [31:0] ref_mem [256];
   int cyc = 0, busy_until = -1, n_cmp = 0, n_fail = 0;
   bit chk_en = 0, mon_en = 0, seen = 0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model_load(logic [31:0] w, int off, int size, bit uns);
      logic [31:0] v;
      v = w >> (8 * off);
      if (size == 0) begin
         v = v & 32'hFF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (size == 1) begin
         v = v & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] model_store(logic [31:0] old, int off, int size,
                                               logic [31:0] wd);
      logic [31:0] mask;
      if (size == 2) return wd;
      mask = ((size == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
      return (old & ~mask) | ((wd << (8 * off)) & mask);
   endfunction

   function automatic bit model_err(logic [31:0] addr, int size);
      return size == 3 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0) ||
             (addr / 4 >= 256);
   endfunction

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic issue(bit wr, logic [1:0] size, bit uns, logic [31:0] addr,
                        logic [31:0] wd, output int t_acc);
      int n = 0;
      int t, widx;
      resp_t r;
      wr_t w;
      req_write = wr; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && n < 40) begin @(negedge clock); n++; end
      if (!req_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout: got ready=0 want ready=1 addr %h", addr);
         req_valid = 1'b0; t_acc = -1;
         return;
      end
      t = cyc + 1; t_acc = t;
      @(posedge clock); #1;
      widx = int'(addr >> 2);
      r.err = model_err(addr, int'(size)); r.rdata = 32'h0;
      if (r.err) r.due = t;
      else if (!wr) begin
         r.rdata = model_load(ref_mem[widx], int'(addr % 4), int'(size), uns);
         r.due = t + 1;
      end else begin
         w.addr = widx;
         w.data = model_store(ref_mem[widx], int'(addr % 4), int'(size), wd);
         ref_mem[widx] = w.data;
         w.due = (size == 2'd2) ? t : t + 1;
         r.due = w.due + 1;
         wq.push_back(w);
      end
      rq.push_back(r);
      busy_until = r.due;
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 30) begin @(negedge clock); n++; end
      if (rq.size() != 0 || wq.size() != 0) begin
         n_cmp++; n_fail++;
         $display("FAIL resp_timeout: got %0d pending want 0", rq.size() + wq.size());
         rq.delete(); wq.delete();
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         bit exp_we, exp_rv;
         while (wq.size() > 0 && wq[0].due < cyc) void'(wq.pop_front());
         while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
         check("req_ready", {31'b0, req_ready}, {31'b0, cyc > busy_until});
         exp_we = wq.size() > 0 && wq[0].due == cyc;
         check("mem_write_enable", {31'b0, mem_write_enable}, {31'b0, exp_we});
         if (exp_we) begin
            check("mem_address", mem_address, wq[0].addr);
            check("mem_write_data", mem_write_data, wq[0].data);
            void'(wq.pop_front());
         end
         exp_rv = rq.size() > 0 && rq[0].due == cyc;
         check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_rv});
         if (exp_rv) begin
            check("resp_rdata", resp_rdata, rq[0].rdata);
            check("resp_error", {31'b0, resp_error}, {31'b0, rq[0].err});
            last_rdata = resp_rdata; last_err = resp_error;
            void'(rq.pop_front());
         end
      end
   end

   always @(mem_write_enable or resp_valid)
      if (mon_en && (mem_write_enable || resp_valid)) seen = 1;

   initial begin
      int t;
      int ta [4];
      for (int i = 0; i < 256; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end

      repeat (2) @(negedge clock);
      check("rst req_ready", {31'b0, req_ready}, 32'd1);
      check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst resp_error", {31'b0, resp_error}, 32'd0);
      check("rst mem_we", {31'b0, mem_write_enable}, 32'd0);
      check("rst resp_rdata", resp_rdata, 32'h0);
      check("rst mem_address", mem_address, 32'h0);
      check("rst mem_wdata", mem_write_data, 32'h0);
      reset = 1'b0;
      @(negedge clock);
      chk_en = 1;

      check("pin model lb", model_load(32'hDEAD55EF, 3, 0, 0), 32'hFFFFFFDE);
      check("pin model sb", model_store(32'hDEADBEEF, 1, 0, 32'h55), 32'hDEAD55EF);

      issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, t); wait_done();
      check("sw word4", tb_mem[4], 32'hDEADBEEF);
      issue(0, 2'd2, 0, 32'h10, 32'h0, t); wait_done();
      check("lw 0x10", last_rdata, 32'hDEADBEEF);
      issue(1, 2'd0, 0, 32'h11, 32'h55, t); wait_done();
      check("sb word4", tb_mem[4], 32'hDEAD55EF);
      issue(0, 2'd0, 0, 32'h13, 32'h0, t); wait_done();
      check("lb 0x13", last_rdata, 32'hFFFFFFDE);
      issue(0, 2'd0, 1, 32'h13, 32'h0, t); wait_done();
      check("lbu 0x13", last_rdata, 32'h000000DE);
      issue(0, 2'd1, 0, 32'h12, 32'h0, t); wait_done();
      check("lh 0x12", last_rdata, 32'hFFFFDEAD);
      issue(0, 2'd1, 1, 32'h10, 32'h0, t); wait_done();
      check("lhu 0x10", last_rdata, 32'h000055EF);
      issue(1, 2'd1, 0, 32'h16, 32'h1234A5B6, t); wait_done();
      check("sh word5", tb_mem[5], 32'hA5B60000);
      issue(1, 2'd0, 0, 32'h17, 32'h80, t); wait_done();
      issue(0, 2'd0, 0, 32'h17, 32'h0, t); wait_done();
      check("lb 0x17", last_rdata, 32'hFFFFFF80);

      issue(1, 2'd2, 0, 32'h02, 32'h12345678, t); wait_done();
      check("err sw 0x02", {31'b0, last_err}, 32'd1);
      check("err sw no write", tb_mem[0], 32'h0);
      issue(0, 2'd1, 0, 32'h01, 32'h0, t); wait_done();
      check("err lh 0x01", {31'b0, last_err}, 32'd1);
      issue(0, 2'd3, 0, 32'h20, 32'h0, t); wait_done();
      check("err size 11", {31'b0, last_err}, 32'd1);
      issue(1, 2'd0, 0, 32'h400, 32'hFF, t); wait_done();
      check("err range", {31'b0, last_err}, 32'd1);

      // Abort a byte store while it is reading the target word.
      issue(1, 2'd2, 0, 32'h20, 32'h11223344, t); wait_done();
      chk_en = 0;
      req_write = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h21; req_wdata = 32'hAA;
      req_valid = 1;
      @(posedge clock); #1;
      req_valid = 0; seen = 0; mon_en = 1;
      reset = 1'b1;
      #1;
      check("abort req_ready", {31'b0, req_ready}, 32'd1);
      check("abort mem_we", {31'b0, mem_write_enable}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      mon_en = 0;
      check("abort no strobe/resp", {31'b0, seen}, 32'd0);
      check("abort word8", tb_mem[8], 32'h11223344);
      rq.delete(); wq.delete(); busy_until = -1;
      chk_en = 1;

      issue(0, 2'd2, 0, 32'h10, 32'h0, ta[0]);
      issue(0, 2'd0, 1, 32'h13, 32'h0, ta[1]);
      issue(0, 2'd1, 0, 32'h16, 32'h0, ta[2]);
      issue(0, 2'd2, 0, 32'h20, 32'h0, ta[3]);
      wait_done();
      for (int i = 1; i < 4; i++) check("b2b spacing", ta[i] - ta[i-1], 32'd3);
      check("b2b last lw", last_rdata, 32'h11223344);

      repeat (2) @(negedge clock);
      chk_en = 0;
      for (int i = 0; i < 16; i++) check("final mem", tb_mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
